// File: rtl/alarm_pkg.sv
// +----------------------------------------------------------------------+
// | alarm_pkg: shared types and BCD field layout for the alarm block      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package alarm_pkg;

  localparam int TIME_W    = 20;
  localparam int SEC_U_LSB = 0;
  localparam int SEC_T_LSB = 4;
  localparam int MIN_U_LSB = 7;
  localparam int MIN_T_LSB = 11;
  localparam int HR_U_LSB  = 14;
  localparam int HR_T_LSB  = 18;

  typedef logic [TIME_W-1:0] bcd_time_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } alarm_state_e;

endpackage

`default_nettype wire

// File: rtl/alarm_beep_gen.sv
// +----------------------------------------------------------------------+
// | alarm_beep_gen: half-period cycle counter driving the beep phase     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module alarm_beep_gen #(
  parameter int unsigned CLOCK_FREQUENCY = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_phase
);

  localparam int unsigned HALF = (CLOCK_FREQUENCY / 2 > 0) ? CLOCK_FREQUENCY / 2 : 1;
  localparam int unsigned CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] TERM = CW'(HALF - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (i_clr) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (i_en) begin
      if (cnt_q == TERM) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign o_phase = phase_q;

endmodule

`default_nettype wire

// File: rtl/alarm_trigger.sv
// +----------------------------------------------------------------------+
// | alarm_trigger: alarm shadow register, match detect, ring/snooze FSM  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module alarm_trigger
  import alarm_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY = 2,
  parameter int unsigned RING_SECONDS    = 60,
  parameter int unsigned SNOOZE_SECONDS  = 300
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [TIME_W-1:0] i_alarm_time,
  input  logic              i_alarm_wr_en,
  input  logic [TIME_W-1:0] i_cur_time,
  input  logic              i_sec_tick,
  input  logic              i_alarm_enable,
  input  logic              i_snooze,
  input  logic              i_stop,
  output logic              o_buzzer,
  output logic              o_ringing,
  output logic              o_snoozing,
  output logic [TIME_W-1:0] o_alarm_reg
);

  localparam int unsigned RW = $clog2(RING_SECONDS + 1);
  localparam int unsigned SW = $clog2(SNOOZE_SECONDS + 1);

  if (RING_SECONDS == 0) begin : g_bad_ring
    $error("alarm_trigger: RING_SECONDS must be nonzero");
  end
  if (SNOOZE_SECONDS == 0) begin : g_bad_snooze
    $error("alarm_trigger: SNOOZE_SECONDS must be nonzero");
  end
  if (CLOCK_FREQUENCY == 0) begin : g_bad_clk
    $error("alarm_trigger: CLOCK_FREQUENCY must be nonzero");
  end

  alarm_state_e  state_q, state_d;
  bcd_time_t     alarm_reg_q;
  logic          armed_q, armed_d;
  logic [RW-1:0] ring_cnt_q, ring_cnt_d;
  logic [SW-1:0] snooze_cnt_q, snooze_cnt_d;
  logic          ringing_q, snoozing_q;
  logic          time_eq, match, beep_clr, phase;

  assign time_eq = (i_cur_time == alarm_reg_q);
  assign match   = i_sec_tick & i_alarm_enable & armed_q & time_eq;

  always_comb begin
    state_d      = state_q;
    ring_cnt_d   = ring_cnt_q;
    snooze_cnt_d = snooze_cnt_q;
    if (!i_alarm_enable) begin
      state_d = IDLE;
    end else if (i_alarm_wr_en && state_q != IDLE) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (match) begin
            state_d    = RING;
            ring_cnt_d = RW'(RING_SECONDS);
          end
        end
        RING: begin
          if (i_stop) begin
            state_d = IDLE;
          end else if (i_snooze) begin
            state_d      = SNOOZE;
            snooze_cnt_d = SW'(SNOOZE_SECONDS);
          end else if (i_sec_tick) begin
            if (ring_cnt_q == RW'(1)) state_d = IDLE;
            else                      ring_cnt_d = ring_cnt_q - 1'b1;
          end
        end
        SNOOZE: begin
          if (i_stop) begin
            state_d = IDLE;
          end else if (i_sec_tick) begin
            if (snooze_cnt_q == SW'(1)) begin
              state_d    = RING;
              ring_cnt_d = RW'(RING_SECONDS);
            end else begin
              snooze_cnt_d = snooze_cnt_q - 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Re-arming needs a tick off the alarm time, so a stopped alarm cannot
  // retrigger within the same matching second.
  always_comb begin
    armed_d = armed_q;
    if (state_q == IDLE && state_d != IDLE) armed_d = 1'b0;
    else if (i_sec_tick && !time_eq)        armed_d = 1'b1;
  end

  assign beep_clr = (state_d == RING) && (state_q != RING);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      alarm_reg_q  <= '0;
      armed_q      <= 1'b1;
      ring_cnt_q   <= '0;
      snooze_cnt_q <= '0;
      ringing_q    <= 1'b0;
      snoozing_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      armed_q      <= armed_d;
      ring_cnt_q   <= ring_cnt_d;
      snooze_cnt_q <= snooze_cnt_d;
      ringing_q    <= (state_d == RING);
      snoozing_q   <= (state_d == SNOOZE);
      if (i_alarm_wr_en) alarm_reg_q <= i_alarm_time;
    end
  end

  alarm_beep_gen #(
    .CLOCK_FREQUENCY(CLOCK_FREQUENCY)
  ) u_beep (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (ringing_q),
    .i_clr  (beep_clr),
    .o_phase(phase)
  );

  assign o_buzzer    = ringing_q & phase;
  assign o_ringing   = ringing_q;
  assign o_snoozing  = snoozing_q;
  assign o_alarm_reg = alarm_reg_q;

endmodule

`default_nettype wire

// File: doc/alarm_trigger.md
Name: alarm_trigger

Overview:
- Consumer of the packed BCD alarm time and its write strobe produced by the alarm-time editor.
- Holds a shadow copy of the alarm time and compares it against the running time-of-day once per second.
- Runs the ring/snooze/stop state machine and drives the buzzer enable and status outputs for the LCD/top level.

Parameters:
- CLOCK_FREQUENCY, 2, i_clk cycles per second; the beep phase toggles every max(CLOCK_FREQUENCY/2,1) cycles.
- RING_SECONDS, 60, seconds the alarm rings before auto-off.
- SNOOZE_SECONDS, 300, seconds spent in snooze before ringing again.

Ports:
- i_clk  in  1  system clock; the block has one clock domain.
- i_rst  in  1  synchronous, active-high reset.
- i_alarm_time  in  20  packed BCD alarm time, field layout below.
- i_alarm_wr_en  in  1  one-cycle strobe; i_alarm_time is valid this cycle.
- i_cur_time  in  20  current time-of-day, same packing.
- i_sec_tick  in  1  one-cycle pulse, once per second, aligned to the i_cur_time update.
- i_alarm_enable  in  1  level; alarm armed when high.
- i_snooze  in  1  one-cycle debounced pulse.
- i_stop  in  1  one-cycle debounced pulse.
- o_buzzer  out  1  gated beep output.
- o_ringing  out  1  high in RING.
- o_snoozing  out  1  high in SNOOZE.
- o_alarm_reg  out  20  current shadow alarm time, for display.

Behaviour:
- Packing:
  - [3:0] sec units
  - [6:4] sec tens
  - [10:7] min units
  - [13:11] min tens
  - [17:14] hour units
  - [19:18] hour tens
  - Comparison is exact 20-bit equality. No range validation is done.
- Reset: alarm_reg=0, state=IDLE, armed=1, counters=0, beep phase=0. All outputs are 0.
- Shadow register:
  - On i_alarm_wr_en, alarm_reg <= i_alarm_time.
  - A write in RING or SNOOZE forces IDLE in the same cycle, because the user is editing.
- match = i_sec_tick & i_alarm_enable & armed & (i_cur_time == alarm_reg).
- armed:
  - Cleared when the FSM leaves IDLE.
  - Set again on any i_sec_tick where i_cur_time != alarm_reg.
  - Purpose: no retrigger within the same matching second after a stop.
- FSM states: IDLE, RING, SNOOZE. All outputs are registered.
  - IDLE -> RING on match. ring_cnt is loaded with RING_SECONDS. o_ringing goes high the cycle after the matching tick.
  - RING, i_stop -> IDLE.
  - RING, i_snooze -> SNOOZE. snooze_cnt is loaded with SNOOZE_SECONDS.
  - RING, i_sec_tick: ring_cnt decrements. On a tick with ring_cnt==1 -> IDLE (auto-off).
  - SNOOZE, i_stop -> IDLE.
  - SNOOZE, i_snooze is ignored.
  - SNOOZE, i_sec_tick: snooze_cnt decrements. On a tick with snooze_cnt==1 -> RING, with ring_cnt reloaded and beep phase cleared.
  - Any state: i_alarm_enable low -> IDLE.
- Priority within one cycle, highest first:
  1. i_rst
  2. !i_alarm_enable
  3. i_alarm_wr_en (when not IDLE)
  4. i_stop
  5. i_snooze
  6. tick-driven count/timeout/match
- Simultaneous stop and snooze: stop wins.
- Counter widths are $clog2(param+1). A parameter of 0 is illegal and must be flagged by an elaboration assertion.
- Beep:
  - The cycle counter runs only in RING and clears on entry to RING.
  - The phase toggles at terminal count.
  - o_buzzer = ringing & phase, so the first beep phase is 0 (silent half-period).
- A tick in the same cycle as entry to RING does not decrement ring_cnt.
- Reset mid-RING/SNOOZE returns to IDLE next edge, and alarm_reg clears.

Decomposition:
- Package alarm_pkg:
  - Field slice constants (SEC_U_LSB etc.) and TIME_W=20.
  - typedef enum logic [1:0] {IDLE, RING, SNOOZE} alarm_state_e.
  - typedef logic [19:0] bcd_time_t.
- One natural sub-module, alarm_beep_gen: cycle counter and phase toggle, with enable and clear inputs. Everything else stays in alarm_trigger.

Test Plan:
- Write 12:30:00 (0x{2'd1,4'd2,3'd3,4'd0,3'd0,4'd0}), enable=1, then drive i_cur_time to that value with a tick -> o_ringing=1 exactly one cycle later. With CLOCK_FREQUENCY=4, o_buzzer toggles every 2 cycles starting at 0.
- Ringing with RING_SECONDS=3: three ticks -> o_ringing falls after the third tick. Further ticks in the same matching second (i_cur_time held) do not retrigger. After i_cur_time changes and matches again -> rings.
- Ringing, then i_snooze with SNOOZE_SECONDS=2 -> o_snoozing=1, o_buzzer=0. Second tick -> RING with ring_cnt reloaded. i_stop -> IDLE with all outputs 0.
- i_stop and i_snooze asserted in the same RING cycle -> IDLE, not SNOOZE. i_alarm_wr_en during SNOOZE -> IDLE, and o_alarm_reg shows the new value the next cycle.
- Drop i_alarm_enable during RING -> IDLE next edge. A match tick with enable=0 -> no ring.
- Assert i_rst during SNOOZE -> next cycle all outputs 0, o_alarm_reg=0. A match on 00:00:00 afterwards rings (armed=1 after reset).
